// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BRK   = 3'd5
    } uart_state_t;

    // Runtime parity selection; code 2'b11 behaves like "none"
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Widest legal data word; narrower words are zero-extended into the helper
    localparam int MAX_DBIT = 9;

    // XOR of all data bits (zero-extension does not change the result)
    function automatic logic calc_parity(input logic [MAX_DBIT-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line front end: 2-FF synchroniser plus 3-sample majority vote.
// Latency: 2 clk from i_rx to o_rxs; vote window advances one sample per i_tick.
// Backpressure: none; free-running, paced only by i_tick.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    input  logic i_tick,
    output logic o_rxs,
    output logic o_voted
);

    logic [1:0] r_sync;
    logic [2:0] r_vote;

    // Two-stage synchroniser, preset to the idle (high) line level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    // Tick-paced history of the synchronised line for majority voting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vote <= 3'b111;
        end else if (i_tick) begin
            r_vote <= {r_vote[1:0], r_sync[1]};
        end
    end

    assign o_rxs   = r_sync[1];
    assign o_voted = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_vote[2]) | (r_vote[1] & r_vote[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime parity, 1/2 stop bits, glitch rejection and break detection.
// Latency: done OVS/2 + (DBIT+P+S)*OVS ticks after the start edge, plus 2-3 clk synchroniser delay.
// Backpressure: none; a frame is reported once via a 1-clk done pulse, outputs held until the next.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OVS  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic [1:0]      cfg_parity,
    input  logic            cfg_stop2,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det
);

    localparam int SW = $clog2(OVS);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic w_rxs;
    logic w_voted;

    uart_rx_sync u_sync (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_rx    (rx),
        .i_tick  (s_tick),
        .o_rxs   (w_rxs),
        .o_voted (w_voted)
    );

    uart_state_t     r_state, w_state_nx;
    logic [SW-1:0]   r_s, w_s_nx;
    logic [NW-1:0]   r_n, w_n_nx;
    logic [DBIT-1:0] r_shift, w_shift_nx;
    logic [1:0]      r_pcfg, w_pcfg_nx;
    logic            r_stop2, w_stop2_nx;
    logic            r_pbit, w_pbit_nx;
    logic            r_sidx, w_sidx_nx;   // 1 once the first of two stop bits is sampled
    logic            r_serr, w_serr_nx;   // stop-bit error seen so far in this frame
    logic            r_brkc, w_brkc_nx;   // break verdict taken at the first stop sample
    logic            r_done, w_done_nx;
    logic [DBIT-1:0] r_dout, w_dout_nx;
    logic            r_perr, w_perr_nx;
    logic            r_ferr, w_ferr_nx;
    logic            r_bdet, w_bdet_nx;

    logic w_par_en;
    logic w_par_odd;
    logic w_par_bad;
    logic w_brk_cand;
    logic w_serr_cur;
    logic w_brk_fin;

    assign w_par_en   = (r_pcfg == PAR_EVEN) || (r_pcfg == PAR_ODD);
    assign w_par_odd  = (r_pcfg == PAR_ODD);
    assign w_par_bad  = w_par_en && ((calc_parity(MAX_DBIT'(r_shift)) ^ r_pbit) != w_par_odd);
    assign w_brk_cand = (r_shift == '0) && (!w_par_en || !r_pbit) && !w_voted;
    assign w_serr_cur = r_serr | ~w_voted;
    assign w_brk_fin  = r_sidx ? r_brkc : w_brk_cand;

    // State, counters, frame capture and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_pcfg  <= PAR_NONE;
            r_stop2 <= 1'b0;
            r_pbit  <= 1'b0;
            r_sidx  <= 1'b0;
            r_serr  <= 1'b0;
            r_brkc  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_bdet  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_n     <= w_n_nx;
            r_shift <= w_shift_nx;
            r_pcfg  <= w_pcfg_nx;
            r_stop2 <= w_stop2_nx;
            r_pbit  <= w_pbit_nx;
            r_sidx  <= w_sidx_nx;
            r_serr  <= w_serr_nx;
            r_brkc  <= w_brkc_nx;
            r_done  <= w_done_nx;
            r_dout  <= w_dout_nx;
            r_perr  <= w_perr_nx;
            r_ferr  <= w_ferr_nx;
            r_bdet  <= w_bdet_nx;
        end
    end

    // Next-state, counter and status logic; everything holds unless a tick moves it
    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_n_nx     = r_n;
        w_shift_nx = r_shift;
        w_pcfg_nx  = r_pcfg;
        w_stop2_nx = r_stop2;
        w_pbit_nx  = r_pbit;
        w_sidx_nx  = r_sidx;
        w_serr_nx  = r_serr;
        w_brkc_nx  = r_brkc;
        w_done_nx  = 1'b0;
        w_dout_nx  = r_dout;
        w_perr_nx  = r_perr;
        w_ferr_nx  = r_ferr;
        w_bdet_nx  = r_bdet;

        case (r_state)
            ST_IDLE: begin
                // Frame format is frozen here so mid-frame config changes are ignored
                if (!w_rxs) begin
                    w_state_nx = ST_START;
                    w_s_nx     = '0;
                    w_pcfg_nx  = cfg_parity;
                    w_stop2_nx = cfg_stop2;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == S_HALF) begin
                        // Line back high at mid start bit: a glitch, drop it silently
                        if (w_rxs) begin
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx = ST_DATA;
                            w_s_nx     = '0;
                            w_n_nx     = '0;
                            w_sidx_nx  = 1'b0;
                            w_serr_nx  = 1'b0;
                            w_brkc_nx  = 1'b0;
                        end
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_nx     = '0;
                        w_shift_nx = {w_voted, r_shift[DBIT-1:1]};
                        if (r_n == N_LAST) begin
                            w_state_nx = w_par_en ? ST_PAR : ST_STOP;
                        end else begin
                            w_n_nx = r_n + 1'b1;
                        end
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_nx     = '0;
                        w_pbit_nx  = w_voted;
                        w_state_nx = ST_STOP;
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_nx = '0;
                        if (r_stop2 && !r_sidx) begin
                            // First of two stop bits: remember error and break verdict
                            w_sidx_nx = 1'b1;
                            w_serr_nx = w_serr_cur;
                            w_brkc_nx = w_brk_cand;
                        end else begin
                            w_done_nx  = 1'b1;
                            w_dout_nx  = r_shift;
                            w_perr_nx  = w_par_bad;
                            w_ferr_nx  = w_serr_cur | w_brk_fin;
                            w_bdet_nx  = w_brk_fin;
                            w_state_nx = w_brk_fin ? ST_BRK : ST_IDLE;
                        end
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            ST_BRK: begin
                // Hold off new frames until the line releases
                if (w_rxs) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign rx_done_tick = r_done;
    assign dout         = r_dout;
    assign parity_err   = r_perr;
    assign frame_err    = r_ferr;
    assign break_det    = r_bdet;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg (DBIT=8, OVS=16) with tick-accurate frame timing.
// Latency: done tick index is measured from the start edge.
// Backpressure: n/a.
module tb_uart_rx_cfg;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;

    int n_chk;
    int n_pass;
    int tick_cnt;
    int done_cnt;
    int done_at;

    uart_rx_cfg #(.DBIT(8), .OVS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .break_det    (break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One s_tick every 4 clocks, changed on the falling edge
    initial begin
        logic [1:0] div;
        div    = 2'd0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            div    = div + 2'd1;
            s_tick = (div == 2'd0);
        end
    end

    // Count done pulses and note the tick index at which each arrives
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_at  = tick_cnt;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the next tick to be consumed by the DUT, then step just past the edge
    task automatic next_tick();
        do @(posedge clk); while (s_tick !== 1'b1);
        #1;
        tick_cnt = tick_cnt + 1;
    endtask

    task automatic drive_for(input logic lvl, input int nticks);
        rx = lvl;
        repeat (nticks) next_tick();
    endtask

    // Drives start, 8 data bits LSB first, optional parity bit and nstop high stop bits.
    // spike_t >= 0 forces the line low for the one tick interval with that index.
    task automatic send_frame(input logic [7:0] d, input int npar, input logic pbit,
                              input int nstop, input int spike_t);
        int   total;
        int   idx;
        logic lvl;
        total    = 16 * (1 + 8 + npar + nstop);
        tick_cnt = 0;
        for (int t = 0; t < total; t++) begin
            idx = t / 16;
            if (idx == 0)                   lvl = 1'b0;
            else if (idx <= 8)              lvl = d[idx-1];
            else if (idx == 9 && npar == 1) lvl = pbit;
            else                            lvl = 1'b1;
            if (t == spike_t) lvl = 1'b0;
            rx = lvl;
            next_tick();
        end
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        tick_cnt   = 0;
        done_cnt   = 0;
        done_at    = -1;
        reset      = 1'b1;
        rx         = 1'b1;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_done",  32'(rx_done_tick), 32'd0);
        chk("rst_dout",  32'(dout),         32'd0);
        chk("rst_perr",  32'(parity_err),   32'd0);
        chk("rst_ferr",  32'(frame_err),    32'd0);
        chk("rst_brk",   32'(break_det),    32'd0);
        reset = 1'b0;
        drive_for(1'b1, 8);

        // 8N1 0xA5
        done_cnt = 0;
        send_frame(8'hA5, 0, 1'b0, 1, -1);
        drive_for(1'b1, 16);
        chk("a5_cnt",  32'(done_cnt),   32'd1);
        chk("a5_at",   32'(done_at),    32'd152);
        chk("a5_dout", 32'(dout),       32'hA5);
        chk("a5_perr", 32'(parity_err), 32'd0);
        chk("a5_ferr", 32'(frame_err),  32'd0);
        chk("a5_brk",  32'(break_det),  32'd0);

        // Same frame with a one-tick low spike next to the bit-0 sample point
        done_cnt = 0;
        send_frame(8'hA5, 0, 1'b0, 1, 22);
        drive_for(1'b1, 16);
        chk("spk_cnt",  32'(done_cnt), 32'd1);
        chk("spk_dout", 32'(dout),     32'hA5);

        // 8E1 0x03 with a wrong parity bit of 1
        cfg_parity = 2'b01;
        done_cnt   = 0;
        send_frame(8'h03, 1, 1'b1, 1, -1);
        drive_for(1'b1, 16);
        chk("e1_cnt",  32'(done_cnt),   32'd1);
        chk("e1_at",   32'(done_at),    32'd168);
        chk("e1_dout", 32'(dout),       32'h03);
        chk("e1_perr", 32'(parity_err), 32'd1);
        chk("e1_ferr", 32'(frame_err),  32'd0);

        // Short low pulse: rejected as a glitch, outputs untouched
        cfg_parity = 2'b00;
        done_cnt   = 0;
        tick_cnt   = 0;
        drive_for(1'b0, 4);
        drive_for(1'b1, 32);
        chk("gl_cnt",  32'(done_cnt),   32'd0);
        chk("gl_dout", 32'(dout),       32'h03);
        chk("gl_perr", 32'(parity_err), 32'd1);
        done_cnt = 0;
        send_frame(8'h5A, 0, 1'b0, 1, -1);
        drive_for(1'b1, 16);
        chk("5a_cnt",  32'(done_cnt),   32'd1);
        chk("5a_dout", 32'(dout),       32'h5A);
        chk("5a_perr", 32'(parity_err), 32'd0);
        chk("5a_ferr", 32'(frame_err),  32'd0);

        // 8N1 0x81 with the stop bit held low over its sample point
        done_cnt = 0;
        send_frame(8'h81, 0, 1'b0, 0, -1);
        drive_for(1'b0, 8);
        drive_for(1'b1, 40);
        chk("fe_cnt",  32'(done_cnt),  32'd1);
        chk("fe_at",   32'(done_at),   32'd152);
        chk("fe_dout", 32'(dout),      32'h81);
        chk("fe_ferr", 32'(frame_err), 32'd1);
        chk("fe_brk",  32'(break_det), 32'd0);

        // Break: line low for 20 bit times
        done_cnt = 0;
        tick_cnt = 0;
        drive_for(1'b0, 320);
        chk("brk_cnt",  32'(done_cnt),  32'd1);
        chk("brk_at",   32'(done_at),   32'd152);
        chk("brk_dout", 32'(dout),      32'h00);
        chk("brk_ferr", 32'(frame_err), 32'd1);
        chk("brk_det",  32'(break_det), 32'd1);
        drive_for(1'b1, 32);
        chk("brk_rel_cnt", 32'(done_cnt), 32'd1);
        done_cnt = 0;
        send_frame(8'h3C, 0, 1'b0, 1, -1);
        drive_for(1'b1, 16);
        chk("3c_cnt",  32'(done_cnt),  32'd1);
        chk("3c_dout", 32'(dout),      32'h3C);
        chk("3c_ferr", 32'(frame_err), 32'd0);
        chk("3c_brk",  32'(break_det), 32'd0);

        // 8O2: reset in the middle of the data bits
        cfg_parity = 2'b10;
        cfg_stop2  = 1'b1;
        done_cnt   = 0;
        tick_cnt   = 0;
        drive_for(1'b0, 16);
        drive_for(1'b1, 34);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mr_dout", 32'(dout),         32'd0);
        chk("mr_done", 32'(rx_done_tick), 32'd0);
        chk("mr_perr", 32'(parity_err),   32'd0);
        chk("mr_ferr", 32'(frame_err),    32'd0);
        chk("mr_brk",  32'(break_det),    32'd0);
        reset = 1'b0;
        drive_for(1'b1, 200);
        chk("mr_cnt", 32'(done_cnt), 32'd0);
        done_cnt = 0;
        send_frame(8'h7E, 1, 1'b1, 2, -1);
        drive_for(1'b1, 16);
        chk("o2_cnt",  32'(done_cnt),   32'd1);
        chk("o2_at",   32'(done_at),    32'd184);
        chk("o2_dout", 32'(dout),       32'h7E);
        chk("o2_perr", 32'(parity_err), 32'd0);
        chk("o2_ferr", 32'(frame_err),  32'd0);
        chk("o2_brk",  32'(break_det),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
